// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared 7-segment definitions: segment bit positions, the digit pattern
// table used by both the encoder and decoder sides, and the receive FSM states.
package sevenseg_scan_decoder_pkg;

  // Segment bit positions within a 7-bit pattern (a is the MSB).
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Legal digit patterns, ordered {a,b,c,d,e,f,g}, active-high.
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1110011;

  // Code reported for any pattern outside the table.
  localparam logic [3:0] BCD_INVALID = 4'hF;

  // Width of the stability counter; large enough for STABLE up to 15.
  localparam int CNT_W = 4;

  // Per-digit qualification states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no valid strobe seen
    ST_QUAL = 2'd1,  // counting identical samples
    ST_HELD = 2'd2   // pattern captured, waiting for a change
  } state_t;

endpackage

// File: rtl/sevenseg_scan_decoder_if.sv
// Scanned 7-segment bus plus the decoded frame it produces.
// master: the side driving the display lines and reading the frame.
// slave:  the decoder.
interface sevenseg_scan_decoder_if #(
  parameter int NDIG = 4
);
  logic [6:0]        seg_in;
  logic [NDIG-1:0]   dig_sel;
  logic [4*NDIG-1:0] bcd_out;
  logic [NDIG-1:0]   digit_err;
  logic              frame_valid;

  modport master (
    output seg_in, dig_sel,
    input  bcd_out, digit_err, frame_valid
  );

  modport slave (
    input  seg_in, dig_sel,
    output bcd_out, digit_err, frame_valid
  );
endinterface

// File: rtl/sevenseg_scan_decoder_seg7_to_bcd.sv
// Combinational 7-segment pattern to BCD lookup. Unknown patterns return
// BCD_INVALID with err set.
module seg7_to_bcd
  import sevenseg_scan_decoder_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       err
);

  // Table lookup against the shared pattern constants.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    bcd = BCD_INVALID;
    err = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Receive side of a scanned 7-segment display. Synchronizes the segment and
// strobe lines, accepts a digit once its pattern has been stable for STABLE
// samples, and publishes a full frame of decoded digits with a 1-cycle pulse.
module sevenseg_scan_decoder
  import sevenseg_scan_decoder_pkg::*;
#(
  parameter int NDIG   = 4,
  parameter int STABLE = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  sevenseg_scan_decoder_if.slave bus
);

  localparam logic [CNT_W-1:0] STABLE_C = STABLE[CNT_W-1:0];

  // Synchronizer stages (seg_m/sel_m are metastability catchers) and the
  // previous synchronized sample used for stability comparison.
  logic [6:0]      seg_m, s_seg, p_seg;
  logic [NDIG-1:0] sel_m, s_sel, p_sel;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  logic            strobe_valid;
  logic            same;
  logic            capture;
  logic            mask_full;

  logic [3:0]      dec_bcd;
  logic            dec_err;

  logic [NDIG-1:0]   mask;
  logic [4*NDIG-1:0] shadow_bcd;
  logic [NDIG-1:0]   shadow_err;

  // Two-flop synchronizers plus one history stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_m <= '0;
      s_seg <= '0;
      p_seg <= '0;
      sel_m <= '0;
      s_sel <= '0;
      p_sel <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage take the pre-edge value, forming a real pipeline.
      seg_m <= bus.seg_in;
      s_seg <= seg_m;
      p_seg <= s_seg;
      sel_m <= bus.dig_sel;
      s_sel <= sel_m;
      p_sel <= s_sel;
    end
  end

  seg7_to_bcd u_dec (
    .seg (s_seg),
    .bcd (dec_bcd),
    .err (dec_err)
  );

  // Sample qualification: one-hot strobe, unchanged sample, capture point.
  always_comb begin
    strobe_valid = $onehot(s_sel);
    same         = (s_sel == p_sel) && (s_seg == p_seg);
    cnt_inc      = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    capture      = (state == ST_QUAL) && strobe_valid && same && (cnt_inc == STABLE_C);
    mask_full    = &mask;
  end

  // Qualification FSM: count consecutive identical samples of a valid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (strobe_valid) begin
            state <= ST_QUAL;
            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt <= '0;
          end
        end
        ST_QUAL: begin
          if (!strobe_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (!same) begin
            cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
          end else if (cnt_inc == STABLE_C) begin
            state <= ST_HELD;
            cnt   <= cnt_inc;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_HELD: begin
          if (!strobe_valid) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (!same) begin
            state <= ST_QUAL;
            cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shadow capture, mask tracking and frame publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shadow is small, so it is reset too; a reset frame can never leak stale digits.
      mask            <= '0;
      shadow_bcd      <= '0;
      shadow_err      <= '0;
      bus.bcd_out     <= '0;
      bus.digit_err   <= '0;
      bus.frame_valid <= 1'b0;
    end else begin
      bus.frame_valid <= mask_full;
      if (mask_full) begin
        bus.bcd_out   <= shadow_bcd;
        bus.digit_err <= shadow_err;
      end
      // A capture on the publishing edge lands in the freshly cleared mask.
      mask <= (mask_full ? '0 : mask) | (capture ? s_sel : '0);
      for (int k = 0; k < NDIG; k++) begin
        if (capture && s_sel[k]) begin
          shadow_bcd[4*k +: 4] <= dec_bcd;
          shadow_err[k]        <= dec_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: a run-length based model of
// the display receiver checked every cycle, plus literal frame expectations.
module tb_sevenseg_scan_decoder;

  localparam int NDIG   = 4;
  localparam int STABLE = 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  sevenseg_scan_decoder_if #(.NDIG(NDIG)) bus ();

  sevenseg_scan_decoder #(.NDIG(NDIG), .STABLE(STABLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference digit patterns, index = BCD value.
  logic [6:0] code_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                7'b1111111, 7'b1110011};

  int vectors     = 0;
  int miscompares = 0;
  int frames      = 0;

  // Model state: pin history, run length of the current synchronized sample,
  // pending frame contents and the expected outputs.
  logic [6:0]  h_seg1, h_seg2, last_seg;
  logic [3:0]  h_sel1, h_sel2, last_sel;
  int          run;
  logic [3:0]  m_mask, m_err, exp_err;
  logic [15:0] m_shadow, exp_bcd;
  logic        exp_fv;

  task automatic model_reset();
    h_seg1 = '0; h_seg2 = '0; last_seg = '0;
    h_sel1 = '0; h_sel2 = '0; last_sel = '0;
    run = 0;
    m_mask = '0; m_err = '0; m_shadow = '0;
    exp_bcd = '0; exp_err = '0; exp_fv = 1'b0;
  endtask

  // One clock edge: the decoder acts on the pin value from two edges ago.
  task automatic model_step();
    logic [6:0] xs;
    logic [3:0] xl;
    logic [3:0] v;
    logic       e;
    xs = h_seg2;
    xl = h_sel2;
    h_seg2 = h_seg1;
    h_sel2 = h_sel1;
    h_seg1 = bus.seg_in;
    h_sel1 = bus.dig_sel;
    if ($countones(xl) == 1)
      run = (xs == last_seg && xl == last_sel) ? run + 1 : 1;
    else
      run = 0;
    last_seg = xs;
    last_sel = xl;
    v = 4'hF;
    e = 1'b1;
    for (int i = 0; i < 10; i++)
      if (code_tab[i] == xs) begin
        v = i[3:0];
        e = 1'b0;
      end
    if (m_mask == 4'hF) begin
      exp_bcd = m_shadow;
      exp_err = m_err;
      exp_fv  = 1'b1;
      m_mask  = '0;
    end else begin
      exp_fv = 1'b0;
    end
    if (run == STABLE)
      for (int k = 0; k < NDIG; k++)
        if (xl[k]) begin
          m_shadow[4*k +: 4] = v;
          m_err[k]  = e;
          m_mask[k] = 1'b1;
        end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Per-cycle comparison on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      vectors++;
      if (bus.frame_valid) frames++;
      if (bus.bcd_out !== exp_bcd || bus.digit_err !== exp_err || bus.frame_valid !== exp_fv) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t: got bcd=%h err=%b fv=%b, want bcd=%h err=%b fv=%b",
                 $time, bus.bcd_out, bus.digit_err, bus.frame_valid, exp_bcd, exp_err, exp_fv);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Drive a strobe/pattern pair for n cycles; inputs change 1 unit after posedge.
  task automatic drive(input logic [3:0] sel, input logic [6:0] seg, input int n);
    bus.dig_sel = sel;
    bus.seg_in  = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scan4(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3, input int n);
    drive(4'b0001, p0, n);
    drive(4'b0010, p1, n);
    drive(4'b0100, p2, n);
    drive(4'b1000, p3, n);
  endtask

  int f0;

  initial begin
    rst_n       = 1'b0;
    bus.seg_in  = '0;
    bus.dig_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_bcd", {16'h0, bus.bcd_out}, 32'h0);
    check("reset_err", {28'h0, bus.digit_err}, 32'h0);
    check("reset_fv", {31'h0, bus.frame_valid}, 32'h0);
    rst_n = 1'b1;
    drive(4'b0000, 7'h00, 2);

    // Basic frame 3,2,1,0.
    f0 = frames;
    scan4(7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 8);
    drive(4'b0000, 7'h00, 6);
    check("frame1_bcd", {16'h0, bus.bcd_out}, 32'h3210);
    check("frame1_err", {28'h0, bus.digit_err}, 32'h0);
    check("frame1_count", frames - f0, 1);

    // Short glitch of 6 on digit 2 followed by a held 9.
    f0 = frames;
    drive(4'b0001, 7'b0110000, 8);
    drive(4'b0010, 7'b0110000, 8);
    drive(4'b0100, 7'b1011111, 2);
    drive(4'b0100, 7'b1110011, 8);
    drive(4'b1000, 7'b0110000, 8);
    drive(4'b0000, 7'h00, 6);
    check("glitch_bcd", {16'h0, bus.bcd_out}, 32'h1911);
    check("glitch_count", frames - f0, 1);

    // Illegal pattern on digit 1.
    f0 = frames;
    scan4(7'b1011011, 7'b0000001, 7'b1011011, 7'b1011011, 8);
    drive(4'b0000, 7'h00, 6);
    check("illegal_bcd", {16'h0, bus.bcd_out}, 32'h55F5);
    check("illegal_err", {28'h0, bus.digit_err}, 32'h2);

    // Multi-hot strobe is ignored; the following scan completes.
    f0 = frames;
    drive(4'b0011, 7'b1111111, 20);
    check("multihot_count", frames - f0, 0);
    check("multihot_bcd", {16'h0, bus.bcd_out}, 32'h55F5);
    scan4(7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 8);
    drive(4'b0000, 7'h00, 6);
    check("after_multihot_bcd", {16'h0, bus.bcd_out}, 32'h4444);
    check("after_multihot_count", frames - f0, 1);

    // Reset after 3 of 4 digits; that partial frame must never appear.
    drive(4'b0001, 7'b1111111, 8);
    drive(4'b0010, 7'b1111111, 8);
    drive(4'b0100, 7'b1111111, 8);
    drive(4'b0000, 7'h00, 2);
    rst_n = 1'b0;
    drive(4'b0000, 7'h00, 3);
    check("midreset_bcd", {16'h0, bus.bcd_out}, 32'h0);
    check("midreset_fv", {31'h0, bus.frame_valid}, 32'h0);
    rst_n = 1'b1;
    f0 = frames;
    drive(4'b1000, 7'b1111111, 8);
    drive(4'b0000, 7'h00, 6);
    check("partial_after_reset_count", frames - f0, 0);
    scan4(7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 8);
    drive(4'b0000, 7'h00, 6);
    check("reset_frame_bcd", {16'h0, bus.bcd_out}, 32'h8888);
    check("reset_frame_count", frames - f0, 1);

    // Continuous fast scan of 7s, three frames back to back.
    f0 = frames;
    for (int f = 0; f < 3; f++)
      scan4(7'b1110000, 7'b1110000, 7'b1110000, 7'b1110000, 4);
    drive(4'b0000, 7'h00, 6);
    check("cont_bcd", {16'h0, bus.bcd_out}, 32'h7777);
    check("cont_count", frames - f0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
